// File: rtl/hc148_irq_encoder.sv
// hc148_irq_encoder: clocked 8-to-3 priority encoder with per-line pending
// latches and a Valid/Ack presentation handshake (74HC148-style pins).
// Optional macro HC148_SYNC_EN: puts a 2-flop synchronizer on inn and ein
// for pins asynchronous to clk (+2 cycles latency). Without it, inn/ein
// must already be synchronous to clk.
module hc148_irq_encoder #(
    parameter bit EDGE = 1'b1            // 1: falling edge sets pending, 0: low level
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] inn,
    input  logic       ein,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ack,
    output logic       gsn,
    output logic       eon,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state;

    logic [7:0] inn_s;        // sampled request lines
    logic       ein_s;        // sampled enable
    logic [7:0] inn_p;        // sampled lines delayed one cycle
    logic [7:0] set_now;      // set requests seen this cycle
    logic [7:0] set_q;        // set requests applied at the next edge
    logic [7:0] clr_mask;
    logic [7:0] pending_nxt;
    logic       valid_nxt;
    logic       enabled;
    logic       accept;
    logic [2:0] top_idx;

`ifdef HC148_SYNC_EN
    logic [7:0] inn_meta;
    logic       ein_meta;

    // Two-flop synchronizer; idles high so reset looks like "no request".
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inn_meta <= '1;
            inn_s    <= '1;
            ein_meta <= 1'b1;
            ein_s    <= 1'b1;
        end else begin
            inn_meta <= inn;
            inn_s    <= inn_meta;
            ein_meta <= ein;
            ein_s    <= ein_meta;
        end
    end
`else
    assign inn_s = inn;
    assign ein_s = ein;
`endif

    assign enabled = ~ein_s;
    assign accept  = valid & ack;

    // Per-line set request: edge or level detect, blocked while disabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        set_now = '0;
        if (enabled) begin
            if (EDGE) set_now = inn_p & ~inn_s;
            else      set_now = ~inn_s;
        end
    end

    // Delay register for edge detection and registered set strobe.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state is updated with <= so every flop sees pre-edge values regardless of statement order.
        if (!rstn) begin
            inn_p <= '1;
            set_q <= '0;
        end else begin
            inn_p <= inn_s;
            set_q <= set_now;
        end
    end

    // Highest-index pending line; later iterations override lower ones.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) top_idx = 3'(i);
        end
    end

    // Next pending vector (set wins over clear) and next Valid.
    always_comb begin
        clr_mask = '0;
        if (accept) clr_mask[code] = 1'b1;
        pending_nxt = (pending & ~clr_mask) | set_q;

        valid_nxt = valid;
        if (state == PRESENT) begin
            if (ack) valid_nxt = 1'b0;
        end else if (enabled && (|pending)) begin
            valid_nxt = 1'b1;
        end
    end

    // Handshake FSM with registered Code/Valid, pending bits and group flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            code    <= 3'd0;
            valid   <= 1'b0;
            pending <= '0;
            gsn     <= 1'b1;
            eon     <= 1'b1;
        end else begin
            pending <= pending_nxt;
            valid   <= valid_nxt;
            gsn     <= ~(enabled & (valid_nxt | (|pending_nxt)));
            eon     <= ~(enabled & ~valid_nxt & ~(|pending_nxt));
            case (state)
                IDLE: begin
                    if (enabled && (|pending)) begin
                        code  <= top_idx;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc148_irq_encoder.sv
// Testbench for hc148_irq_encoder: one level-mode and one edge-mode instance
// driven by the same pins, both checked every cycle against a reference model
// built from the request timing rules (history of captured pin values).
module tb_hc148_irq_encoder;

`ifdef HC148_SYNC_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif
    localparam int HD = 6;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] inn;
    logic       ein;
    logic       ack;

    logic [2:0] code_l, code_e;
    logic       valid_l, valid_e;
    logic       gsn_l, gsn_e, eon_l, eon_e;
    logic [7:0] pending_l, pending_e;

    hc148_irq_encoder #(.EDGE(1'b0)) dut_l (
        .clk(clk), .rstn(rstn), .inn(inn), .ein(ein),
        .code(code_l), .valid(valid_l), .ack(ack),
        .gsn(gsn_l), .eon(eon_l), .pending(pending_l)
    );

    hc148_irq_encoder #(.EDGE(1'b1)) dut_e (
        .clk(clk), .rstn(rstn), .inn(inn), .ein(ein),
        .code(code_e), .valid(valid_e), .ack(ack),
        .gsn(gsn_e), .eon(eon_e), .pending(pending_e)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: h_*[j] is the pin value captured j edges ago.
    logic [7:0] h_inn [HD];
    logic       h_ein [HD];
    logic [7:0] m_pend  [2];   // index 0 = level mode, 1 = edge mode
    logic [2:0] m_code  [2];
    logic       m_valid [2];
    logic       m_gsn   [2];
    logic       m_eon   [2];

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < HD; j++) begin
            h_inn[j] = 8'hFF;
            h_ein[j] = 1'b1;
        end
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = 8'h00;
            m_code[m]  = 3'd0;
            m_valid[m] = 1'b0;
            m_gsn[m]   = 1'b1;
            m_eon[m]   = 1'b1;
        end
    endtask

    // One rising edge: a line captured low at edge e sets pending at e+SD+1;
    // the enable captured at edge e governs issue at e+SD.
    task automatic model_edge();
        logic       en;
        logic [7:0] set;
        logic [7:0] keep;
        for (int j = HD - 1; j > 0; j--) begin
            h_inn[j] = h_inn[j-1];
            h_ein[j] = h_ein[j-1];
        end
        h_inn[0] = inn;
        h_ein[0] = ein;
        en = !h_ein[SD];
        for (int m = 0; m < 2; m++) begin
            set = 8'h00;
            if (!h_ein[SD+1]) begin
                for (int i = 0; i < 8; i++) begin
                    if (!h_inn[SD+1][i] && (m == 0 || h_inn[SD+2][i])) set[i] = 1'b1;
                end
            end
            keep = m_pend[m];
            if (m_valid[m]) begin
                if (ack) begin
                    m_valid[m] = 1'b0;
                    keep[m_code[m]] = 1'b0;
                end
            end else if (en && m_pend[m] != 8'h00) begin
                m_code[m]  = highest(m_pend[m]);
                m_valid[m] = 1'b1;
            end
            m_pend[m] = keep | set;
            m_gsn[m]  = !(en && (m_valid[m] || m_pend[m] != 8'h00));
            m_eon[m]  = !(en && !m_valid[m] && m_pend[m] == 8'h00);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("code_l",    32'(code_l),    32'(m_code[0]));
        check("valid_l",   32'(valid_l),   32'(m_valid[0]));
        check("gsn_l",     32'(gsn_l),     32'(m_gsn[0]));
        check("eon_l",     32'(eon_l),     32'(m_eon[0]));
        check("pending_l", 32'(pending_l), 32'(m_pend[0]));
        check("code_e",    32'(code_e),    32'(m_code[1]));
        check("valid_e",   32'(valid_e),   32'(m_valid[1]));
        check("gsn_e",     32'(gsn_e),     32'(m_gsn[1]));
        check("eon_e",     32'(eon_e),     32'(m_eon[1]));
        check("pending_e", 32'(pending_e), 32'(m_pend[1]));
    endtask

    // Called at a falling edge: drive, clock once, compare at the next falling edge.
    task automatic step(input logic [7:0] i_v, input logic e_v, input logic a_v);
        inn = i_v;
        ein = e_v;
        ack = a_v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Idle with Ack low until the edge-mode instance presents, bounded.
    task automatic wait_valid_e(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            step(8'hFF, 1'b0, 1'b0);
            if (valid_e) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        int         n;
        int         first_l;
        logic [2:0] got [$];

        rstn = 1'b0;
        inn  = 8'hFF;
        ein  = 1'b0;
        ack  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("reset_eon", 32'(eon_e), 32'd1);
        rstn = 1'b1;

        // Enabled with no requests: EON falls, nothing issues.
        repeat (4) step(8'hFF, 1'b0, 1'b0);
        check("idle_eon", 32'(eon_e), 32'd0);

        // Single-cycle pulse on line 5 with Ack held high: latency to Valid.
        step(8'hDF, 1'b0, 1'b1);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            step(8'hFF, 1'b0, 1'b1);
            if (valid_e && lat < 0) begin
                lat = k;
                check("pulse5_code", 32'(code_e), 32'd5);
            end
        end
        check("pulse5_latency", 32'(lat), 32'(SD + 2));
        check("pulse5_cleared", 32'(pending_e), 32'd0);

        // Lines 6, 2, 0 fall together: delivered in priority order.
        got.delete();
        for (int k = 0; k < 14; k++) begin
            step(8'hBA, 1'b0, 1'b1);
            if (valid_e) got.push_back(code_e);
        end
        check("multi_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("multi_first",  32'(got[0]), 32'd6);
            check("multi_second", 32'(got[1]), 32'd2);
            check("multi_third",  32'(got[2]), 32'd0);
        end
        repeat (8) step(8'hFF, 1'b0, 1'b1);
        check("multi_eon", 32'(eon_e), 32'd0);

        // Code 3 presented, line 7 falls: Code holds until accepted, then 7.
        step(8'hF7, 1'b0, 1'b0);
        wait_valid_e(10, n);
        check("hold3_seen", 32'(n > 0), 32'd1);
        step(8'h7F, 1'b0, 1'b0);
        repeat (5) step(8'hFF, 1'b0, 1'b0);
        check("hold3_code", 32'(code_e), 32'd3);
        step(8'hFF, 1'b0, 1'b1);
        wait_valid_e(6, n);
        check("next7_code", 32'(code_e), 32'd7);
        step(8'hFF, 1'b0, 1'b1);
        repeat (6) step(8'hFF, 1'b0, 1'b1);

        // Disabled while line 4 falls; then enable with line 4 still low.
        repeat (6) step(8'hEF, 1'b1, 1'b1);
        check("dis_gsn", 32'(gsn_l), 32'd1);
        check("dis_eon", 32'(eon_l), 32'd1);
        check("dis_pending", 32'(pending_l), 32'd0);
        first_l = -1;
        for (int k = 0; k < 10; k++) begin
            step(8'hEF, 1'b0, 1'b1);
            if (valid_l && first_l < 0) first_l = int'(code_l);
        end
        check("level4_code", 32'(first_l), 32'd4);
        check("level4_reset", 32'(pending_l[4]), 32'd1);
        repeat (8) step(8'hFF, 1'b0, 1'b1);

        // Accept coinciding with a new set on the same line: set wins.
        step(8'hFD, 1'b0, 1'b0);
        wait_valid_e(10, n);
        check("same_seen", 32'(n > 0), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step((k == 4 - SD) ? 8'hFD : 8'hFF, 1'b0, (k == 5) ? 1'b1 : 1'b0);
        end
        check("same_valid_low", 32'(valid_e), 32'd0);
        check("same_pending", 32'(pending_e[1]), 32'd1);
        step(8'hFF, 1'b0, 1'b0);
        check("same_reissue", 32'(valid_e), 32'd1);
        check("same_code", 32'(code_e), 32'd1);
        repeat (6) step(8'hFF, 1'b0, 1'b1);

        // Randomized traffic: sparse falling lines, occasional disable.
        for (int k = 0; k < 300; k++) begin
            step(~(8'($urandom) & 8'($urandom) & 8'($urandom)),
                 ($urandom_range(0, 7) == 0), 1'($urandom));
        end
        repeat (10) step(8'hFF, 1'b0, 1'b1);

        // Asynchronous reset while a Code is presented.
        step(8'hBF, 1'b0, 1'b0);
        wait_valid_e(10, n);
        check("rst_mid_seen", 32'(n > 0), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_valid_e", 32'(valid_e), 32'd0);
        check("rst_mid_valid_l", 32'(valid_l), 32'd0);
        check("rst_mid_pending", 32'(pending_e), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rstn = 1'b1;
        repeat (4) step(8'hFF, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hc148_irq_encoder.md
# hc148_irq_encoder

Clocked 8-to-3 priority encoder, the encode-side counterpart of the HC138 3-to-8 decoder. It accepts eight active-low request lines in 74HC148 style and latches them into per-line pending bits. It then presents the highest-priority pending index to a consumer over a Valid/Ack handshake. It sits between external interrupt or request pins and the control logic that drives the HC138 select lines.

## Interface
- EDGE, default 1: 1 = a falling edge on a request line sets its pending bit; 0 = a sampled low level sets it every cycle.
- CLK  input  1  single clock, rising-edge.
- RSTN  input  1  asynchronous active-low reset.
- INN  input  8  request lines, active-low; bit 7 has highest priority.
- EIN  input  1  enable, active-low; sampled like INN.
- Code  output  3  index of the presented request, active-high binary.
- Valid  output  1  Code is valid and held stable.
- Ack  input  1  consumer accepts Code when high while Valid is high.
- GSN  output  1  group select, active-low: enabled and (Valid or any pending).
- EON  output  1  enable out, active-low: enabled, no pending, Valid low.
- Pending  output  8  pending bit per line, for debug.

## Operation
- Input path: INN and EIN each pass through a sample stage `s`, then a delay register `p`. Edge event for line i = `p[i] & ~s[i]`.
- Pending set:
  - EDGE=1: set on the edge event.
  - EDGE=0: set whenever `~s[i]`.
  - Sets are allowed only while the sampled EIN is low.
- Pending clear: on an accept (Valid & Ack), `pending[Code]` clears. If a set for the same line occurs in the same cycle, the set wins and the bit stays 1.
- While the sampled EIN is high:
  - No new sets.
  - Existing pending bits are retained.
  - No new issue; a transaction already in PRESENT still completes.
- FSM with two states:
  - IDLE: if enabled and `|pending`, load Code with the highest set index, drive Valid=1 and go to PRESENT.
  - PRESENT: Code and Valid are held regardless of new pending sets. On accept, clear the pending bit, drive Valid=0 and go to IDLE.
- Throughput: at most one accept every 2 cycles, because IDLE always takes one bubble cycle.
- GSN and EON are registered from next-state values. Both are 1 while the sampled EIN is high.
- Reset values: pending=0, s and p=all 1s, Code=0, Valid=0, GSN=1, EON=1, state IDLE.
- Reset asserted mid-transaction drops Valid immediately and discards all pending bits.

## Timing
- Edge 0 is the first rising edge at which a low INN is captured by the first register.
- With HC148_SYNC_EN: pending set at edge 3, Valid=1 at edge 4.
- Without HC148_SYNC_EN: pending set at edge 1, Valid=1 at edge 2.
- Ack is sampled at the rising edge. Accept at edge n gives Valid=0 after edge n. The earliest next Valid is after edge n+1.
- Ack while Valid=0 is ignored.
- GSN and EON update on the same edge as the pending and Valid changes that cause them.

## Configuration
- HC148_SYNC_EN defined: sample stage `s` is a 2-flop synchronizer, reset to 1, on INN and EIN. This adds 2 cycles of latency and is required for asynchronous pins.
- HC148_SYNC_EN undefined: `s` is INN/EIN directly (combinational). This is only for inputs already synchronous to CLK.
- The handshake and priority behaviour are otherwise identical in both builds.

## Test plan
- Reset with all INN=FF and EIN=0: Valid=0, Code=0, GSN=1, EON=0 once enabled; assert RSTN=0 mid-PRESENT and check Valid drops to 0 asynchronously.
- EDGE=1, SYNC on, pulse INN[5] low for 1 cycle, Ack held high: Valid=1 with Code=5 at edge 4, accepted at that edge, pending=00 afterwards.
- INN[2], INN[6] and INN[0] fall in the same cycle, Ack high: Codes delivered in order 6, 2, 0, one every 2 cycles, then EON=0.
- While Code=3 is presented, INN[7] falls: Code stays 3 until Ack; the next issue is 7.
- EIN=1 while INN[4] falls: pending stays 00, GSN=1, EON=1; then EIN=0 with INN[4] still low and EDGE=0: Code=4 issued, and pending[4] sets again after accept (set-wins).
- Ack and a new edge on the same line in the same cycle: pending stays set and the same Code re-issues 2 cycles later.
